// File: rtl/bus_pkg.sv
// Shared constants and types for the bus arbiter: device IDs, header field positions, FSM states.
package bus_pkg;

    localparam logic [1:0]  ID_CTRL     = 2'd3;
    localparam int unsigned HDR_SRC_LSB = 2;
    localparam int unsigned HDR_DST_LSB = 4;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StTurn,
        StXfer,
        StDone
    } state_e;

    function automatic logic [3:0] id_onehot(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Combinational 3-way round-robin picker: highest priority is the requester just after ptr.
module rr_arb3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] pick,
    output logic       any
);

    logic [1:0] first, second, third;

    always_comb begin
        first  = 2'd0;
        second = 2'd1;
        third  = 2'd2;
        case (ptr)
            2'd0: begin
                first  = 2'd1;
                second = 2'd2;
                third  = 2'd0;
            end
            2'd1: begin
                first  = 2'd2;
                second = 2'd0;
                third  = 2'd1;
            end
            default: begin
                first  = 2'd0;
                second = 2'd1;
                third  = 2'd2;
            end
        endcase
    end

    // Later assignments override earlier ones, so the lowest-offset requester wins.
    always_comb begin
        pick = first;
        if (req[third])  pick = third;
        if (req[second]) pick = second;
        if (req[first])  pick = first;
    end

    assign any = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus scheduler: round-robin arbitration, control-unit header beat, fixed turnaround,
// source ownership until its last beat, then a one-cycle ack (with err on protocol faults).
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 3,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       bus_valid,
    input  logic [7:0] bus_data,
    input  logic       last,
    output logic [3:0] grant,
    output logic [1:0] hdr_src,
    output logic [1:0] cur_src,
    output logic [1:0] cur_dst,
    output logic       busy,
    output logic       ack,
    output logic       err
);

    localparam logic [CNT_W-1:0] TURN_LAST    = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       rr_ptr_q;
    logic [1:0]       arb_pick;
    logic             arb_any;
    logic [1:0]       hdr_src_field;
    logic [1:0]       hdr_dst_field;
    logic             unused_hdr_bits;

    rr_arb3 u_rr_arb3 (
        .req  (req),
        .ptr  (rr_ptr_q),
        .pick (arb_pick),
        .any  (arb_any)
    );

    assign hdr_src_field   = bus_data[HDR_SRC_LSB +: 2];
    assign hdr_dst_field   = bus_data[HDR_DST_LSB +: 2];
    assign unused_hdr_bits = ^{bus_data[7:6], bus_data[1:0]};
    assign cnt_inc         = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // Outputs are registered alongside the state so they change with it. An undriven (x/z)
    // bus_valid fails the if-test and so behaves as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rr_ptr_q <= 2'd2;
            grant    <= 4'b0000;
            hdr_src  <= 2'd0;
            cur_src  <= 2'd0;
            cur_dst  <= 2'd0;
            busy     <= 1'b0;
            ack      <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (arb_any) begin
                        hdr_src  <= arb_pick;
                        rr_ptr_q <= arb_pick;
                        grant    <= id_onehot(ID_CTRL);
                        busy     <= 1'b1;
                        state_q  <= StHdr;
                    end
                end
                StHdr: begin
                    if (bus_valid) begin
                        cur_src <= hdr_src_field;
                        cur_dst <= hdr_dst_field;
                        grant   <= 4'b0000;
                        if (hdr_src_field != hdr_src || last) begin
                            ack     <= 1'b1;
                            err     <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= StTurn;
                        end
                    end
                end
                StTurn: begin
                    if (cnt_q == TURN_LAST) begin
                        cnt_q   <= '0;
                        grant   <= id_onehot(cur_src);
                        state_q <= StXfer;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StXfer: begin
                    if (bus_valid) begin
                        cnt_q <= '0;
                        if (last) begin
                            grant   <= 4'b0000;
                            ack     <= 1'b1;
                            state_q <= StDone;
                        end
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        grant   <= 4'b0000;
                        ack     <= 1'b1;
                        err     <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StDone: begin
                    ack     <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    grant   <= 4'b0000;
                    state_q <= StIdle;
                end
                default: begin
                    grant   <= 4'b0000;
                    busy    <= 1'b0;
                    ack     <= 1'b0;
                    err     <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter: driver plays endpoints and control unit,
// a monitor pops expected transaction outcomes whenever ack/err is seen.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic       bus_valid;
    logic [7:0] bus_data;
    logic       last;
    logic [3:0] grant;
    logic [1:0] hdr_src;
    logic [1:0] cur_src;
    logic [1:0] cur_dst;
    logic       busy;
    logic       ack;
    logic       err;

    always #5 clk = ~clk;

    bus_arbiter #(
        .TURN_CYCLES (3),
        .TIMEOUT     (255),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .last      (last),
        .grant     (grant),
        .hdr_src   (hdr_src),
        .cur_src   (cur_src),
        .cur_dst   (cur_dst),
        .busy      (busy),
        .ack       (ack),
        .err       (err)
    );

    typedef struct {
        int src;
        int csrc;
        int cdst;
        bit err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   rr_last = 2;
    int   last_hdr_src;
    int   order[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference arbitration: first requester in cyclic order after the last one served.
    function automatic int model_pick(input logic [2:0] r);
        for (int k = 1; k <= 3; k++) begin
            int id;
            id = (rr_last + k) % 3;
            if (r[id]) return id;
        end
        return -1;
    endfunction

    function automatic logic [7:0] mk_hdr(input int s, input int d);
        logic [7:0] h;
        h      = 8'($urandom) & 8'hC3;
        h[3:2] = 2'(s);
        h[5:4] = 2'(d);
        return h;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (ack === 1'b1 || err === 1'b1)) begin
            if (sb.size() == 0) begin
                check("ack_without_txn", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("ack_with_err", {31'd0, ack}, 32'd1);
                check("err_flag", {31'd0, err}, {31'd0, mon_e.err});
                check("cur_src", {30'd0, cur_src}, mon_e.csrc);
                check("cur_dst", {30'd0, cur_dst}, mon_e.cdst);
                check("served_src", {30'd0, hdr_src}, mon_e.src);
            end
        end
    end

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_hdr_src", {30'd0, hdr_src}, 32'd0);
        check("rst_cur_src", {30'd0, cur_src}, 32'd0);
        req       = 3'b000;
        bus_valid = 1'b0;
        last      = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        rr_last = 2;
    endtask

    // Arbitration, header beat and turnaround; returns at the first XFER negedge.
    task automatic start_hdr(input logic [2:0] r, input bit bad, input bit hlast, input int dst,
                             input bit abort_turn, input bit expect_ack,
                             output int hsrc, output bit aborted);
        int src_exp;
        src_exp = model_pick(r);
        rr_last = src_exp;
        hsrc    = bad ? (src_exp + 1) % 3 : src_exp;
        aborted = 1'b0;
        if (expect_ack) sb.push_back('{src_exp, hsrc, dst, bad || hlast});
        req = r;
        @(negedge clk);
        last_hdr_src = int'(hdr_src);
        check("hdr_grant", {28'd0, grant}, 32'b1000);
        check("hdr_src", {30'd0, hdr_src}, src_exp);
        check("hdr_busy", {31'd0, busy}, 32'd1);
        repeat ($urandom_range(0, 2)) begin
            bus_valid = 1'b0;
            last      = 1'b1;
            @(negedge clk);
            check("hdr_wait_grant", {28'd0, grant}, 32'b1000);
        end
        bus_valid = 1'b1;
        bus_data  = mk_hdr(hsrc, dst);
        last      = hlast;
        @(negedge clk);
        bus_valid = 1'b0;
        last      = 1'b0;
        if (bad || hlast) return;
        for (int i = 0; i < 3; i++) begin
            check("turn_grant", {28'd0, grant}, 32'd0);
            if (abort_turn && i == 1) begin
                do_reset();
                aborted = 1'b1;
                return;
            end
            bus_valid = 1'($urandom);
            bus_data  = 8'($urandom);
            last      = 1'($urandom);
            @(negedge clk);
        end
        bus_valid = 1'b0;
        last      = 1'b0;
        check("xfer_grant", {28'd0, grant}, 32'd1 << hsrc);
    endtask

    task automatic finish_done();
        check("done_ack", {31'd0, ack}, 32'd1);
        check("done_grant", {28'd0, grant}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd1);
        bus_valid = 1'b0;
        last      = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", {31'd0, ack}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic txn(input logic [2:0] r, input bit bad, input bit hlast, input int dst,
                       input int nbeats, input int gap_max);
        int hsrc;
        bit ab;
        start_hdr(r, bad, hlast, dst, 1'b0, 1'b1, hsrc, ab);
        if (!(bad || hlast)) begin
            for (int b = 0; b < nbeats; b++) begin
                repeat ($urandom_range(0, gap_max)) begin
                    bus_valid = 1'b0;
                    last      = 1'b1;
                    req       = 3'($urandom);
                    @(negedge clk);
                    check("xfer_hold", {28'd0, grant}, 32'd1 << hsrc);
                end
                bus_valid = 1'b1;
                bus_data  = 8'($urandom);
                last      = (b == nbeats - 1);
                @(negedge clk);
                if (b != nbeats - 1) check("xfer_beat", {28'd0, grant}, 32'd1 << hsrc);
            end
            bus_valid = 1'b0;
            last      = 1'b0;
        end
        finish_done();
    endtask

    task automatic txn_timeout(input logic [2:0] r, input int beat_at);
        int hsrc;
        int k;
        bit ab;
        start_hdr(r, 1'b0, 1'b0, 0, 1'b0, 1'b1, hsrc, ab);
        sb[sb.size() - 1].err = 1'b1;
        k = 0;
        while (ack !== 1'b1 && k < 600) begin
            bus_valid = (k == beat_at);
            bus_data  = 8'($urandom);
            last      = 1'b0;
            @(negedge clk);
            k++;
        end
        bus_valid = 1'b0;
        check("timeout_cycles", k - 1, (beat_at >= 0) ? beat_at + 255 : 254);
        finish_done();
    endtask

    initial begin
        int hsrc;
        bit ab;
        rst_n     = 1'b0;
        req       = 3'b000;
        bus_valid = 1'b0;
        bus_data  = 8'h00;
        last      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_grant", {28'd0, grant}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_hdr_src", {30'd0, hdr_src}, 32'd0);
        check("reset_cur_src", {30'd0, cur_src}, 32'd0);
        check("reset_cur_dst", {30'd0, cur_dst}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester 1, src1/dst2, four back-to-back beats.
        txn(3'b010, 1'b0, 1'b0, 2, 4, 0);

        // All requesting: served in order 0,1,2,0 out of reset.
        req = 3'b000;
        do_reset();
        for (int t = 0; t < 4; t++) begin
            txn(3'b111, 1'b0, 1'b0, t, 2, 1);
            order[t] = last_hdr_src;
        end
        check("rr_order0", order[0], 32'd0);
        check("rr_order1", order[1], 32'd1);
        check("rr_order2", order[2], 32'd2);
        check("rr_order3", order[3], 32'd0);

        // Header names the wrong source.
        req = 3'b000;
        do_reset();
        txn(3'b001, 1'b1, 1'b0, 1, 1, 0);

        // Timeout with no beats, then with one beat partway through.
        req = 3'b000;
        @(negedge clk);
        txn_timeout(3'b001, -1);
        txn_timeout(3'b010, 200);

        // Reset during TURN, then during XFER; arbitration restarts from pointer 2.
        txn(3'b001, 1'b0, 1'b0, 0, 1, 0);
        start_hdr(3'b111, 1'b0, 1'b0, 2, 1'b1, 1'b0, hsrc, ab);
        txn(3'b111, 1'b0, 1'b0, 1, 1, 0);
        check("post_rst_turn_pick", last_hdr_src, 32'd0);
        start_hdr(3'b100, 1'b0, 1'b0, 0, 1'b0, 1'b0, hsrc, ab);
        bus_valid = 1'b1;
        last      = 1'b0;
        @(negedge clk);
        bus_valid = 1'b0;
        do_reset();
        txn(3'b110, 1'b0, 1'b0, 3, 2, 2);
        check("post_rst_xfer_pick", last_hdr_src, 32'd1);

        // Last on the header beat; then a lone requester served twice.
        txn(3'b001, 1'b0, 1'b1, 3, 1, 0);
        txn(3'b100, 1'b0, 1'b0, 2, 2, 2);
        txn(3'b100, 1'b0, 1'b0, 2, 1, 2);

        for (int n = 0; n < 25; n++) begin
            logic [2:0] r;
            r = 3'($urandom_range(1, 7));
            txn(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 5)), 3);
            if ($urandom_range(0, 2) == 0) begin
                req = 3'b000;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        req = 3'b000;
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
